// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe win scanner.
// Holds the 2-bit cell encodings, the line direction enum, the scan FSM
// state enum and a helper that picks the lowest matching direction.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;
  localparam logic [1:0] CELL_BAD   = 2'b11;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    DIAG  = 2'd2,
    ADIAG = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Lowest-numbered direction with a hit; RIGHT when nothing is set.
  function automatic dir_e first_dir(input logic [3:0] hits);
    dir_e d;
    d = RIGHT;
    if (hits[0]) begin
      d = RIGHT;
    end else if (hits[1]) begin
      d = DOWN;
    end else if (hits[2]) begin
      d = DIAG;
    end else if (hits[3]) begin
      d = ADIAG;
    end else begin
      d = RIGHT;
    end
    return d;
  endfunction

endpackage

// File: rtl/line_checker.sv
// Combinational test of the four K-long lines that start at cell (r,c).
// Ports:
//   snap     in  2*N*N  board snapshot, cell i=row*N+col at [2i+1:2i]
//   r, c     in  CW     start coordinate
//   fit      out 4      line fits on the board, per direction
//   p1_match out 4      line is all player 1 (only where it fits)
//   p2_match out 4      line is all player 2 (only where it fits)
// Direction order: 0 right, 1 down, 2 down-right, 3 down-left.
module line_checker
  import ttt_pkg::*;
#(
  parameter int N = 5,
  parameter int K = 3
) (
  input  logic [2*N*N-1:0]     snap,
  input  logic [$clog2(N)-1:0] r,
  input  logic [$clog2(N)-1:0] c,
  output logic [3:0]           fit,
  output logic [3:0]           p1_match,
  output logic [3:0]           p2_match
);

  int         ri_s;
  int         ci_s;
  int         rr_s;
  int         cc_s;
  int         idx_s;
  logic [1:0] cell_s;

  // Fit tests and per-direction all-same-player reduction over K cells.
  always_comb begin
    ri_s   = int'(r);
    ci_s   = int'(c);
    rr_s   = 0;
    cc_s   = 0;
    idx_s  = 0;
    cell_s = CELL_EMPTY;

    fit[0] = (ci_s + K - 1) < N;
    fit[1] = (ri_s + K - 1) < N;
    fit[2] = fit[0] && fit[1];
    fit[3] = fit[1] && (ci_s >= K - 1);

    p1_match = fit;
    p2_match = fit;

    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < K; k++) begin
        rr_s = (d == 0) ? ri_s : ri_s + k;
        case (d)
          0:       cc_s = ci_s + k;
          1:       cc_s = ci_s;
          2:       cc_s = ci_s + k;
          3:       cc_s = ci_s - k;
          default: cc_s = ci_s;
        endcase
        // Non-fitting lines may point off the board; park the index at 0.
        idx_s  = fit[d] ? (rr_s * N + cc_s) : 0;
        cell_s = snap[2*idx_s +: 2];
        if (cell_s != CELL_P1) begin
          p1_match[d] = 1'b0;
        end else begin
          p1_match[d] = p1_match[d];
        end
        if (cell_s != CELL_P2) begin
          p2_match[d] = 1'b0;
        end else begin
          p2_match[d] = p2_match[d];
        end
      end
    end
  end

endmodule

// File: rtl/win_scanner_chk.sv
// Elaboration-time parameter range checks for win_scanner.
// Parameters: N (board side, 3..8), K (win length, 3..N). No ports.
module win_scanner_chk #(
  parameter int N = 5,
  parameter int K = 3
) ();

  if ((N < 3) || (N > 8)) begin : g_bad_n
    $error("win_scanner: N=%0d outside 3..8", N);
  end

  if ((K < 3) || (K > N)) begin : g_bad_k
    $error("win_scanner: K=%0d outside 3..N", K);
  end

endmodule

// File: rtl/win_scanner.sv
// Sequential win scanner for an N x N board with K-in-a-row wins.
// On an accepted start the board is snapshotted and every cell is visited
// in row-major order, one per clock, testing the four lines starting there.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             scan request, honoured only while busy=0
//   board   [2NN]     board bus (00 empty, 01 P1, 10 P2, 11 illegal)
//   busy              scan in progress
//   done              one-cycle pulse, results final from here on
//   p1_win, p2_win    some line is all P1 / all P2
//   draw              no win and no empty cell
//   illegal           some cell encoded 11
//   win_row/win_col   start of first winning line (CW bits)
//   win_dir           direction of first winning line
module win_scanner
  import ttt_pkg::*;
#(
  parameter int N = 5,
  parameter int K = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*N*N-1:0]     board,
  output logic                 busy,
  output logic                 done,
  output logic                 p1_win,
  output logic                 p2_win,
  output logic                 draw,
  output logic                 illegal,
  output logic [$clog2(N)-1:0] win_row,
  output logic [$clog2(N)-1:0] win_col,
  output logic [1:0]           win_dir
);

  localparam int CW = $clog2(N);
  localparam int IW = $clog2(N * N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);
  localparam logic [IW-1:0] N_W      = IW'(N);

  scan_state_e     state_r;
  scan_state_e     state_s;
  logic [2*N*N-1:0] snap_r;
  logic [IW-1:0]   idx_r;
  logic            found_r;
  logic            any_empty_r;

  logic [CW-1:0]   row_s;
  logic [CW-1:0]   col_s;
  logic [1:0]      cell_s;
  logic [3:0]      fit_s;
  logic [3:0]      p1m_s;
  logic [3:0]      p2m_s;
  logic [3:0]      hit_s;

  win_scanner_chk #(.N(N), .K(K)) u_chk ();

  assign row_s  = CW'(idx_r / N_W);
  assign col_s  = CW'(idx_r % N_W);
  assign cell_s = snap_r[{idx_r, 1'b0} +: 2];
  assign hit_s  = p1m_s | p2m_s;

  line_checker #(.N(N), .K(K)) u_line (
    .snap     (snap_r),
    .r        (row_s),
    .c        (col_s),
    .fit      (fit_s),
    .p1_match (p1m_s),
    .p2_match (p2m_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Snapshot, cell index and sticky result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r      <= '0;
      idx_r       <= '0;
      found_r     <= 1'b0;
      any_empty_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      p1_win      <= 1'b0;
      p2_win      <= 1'b0;
      draw        <= 1'b0;
      illegal     <= 1'b0;
      win_row     <= '0;
      win_col     <= '0;
      win_dir     <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap_r      <= board;
            idx_r       <= '0;
            found_r     <= 1'b0;
            any_empty_r <= 1'b0;
            busy        <= 1'b1;
            p1_win      <= 1'b0;
            p2_win      <= 1'b0;
            draw        <= 1'b0;
            illegal     <= 1'b0;
            win_row     <= '0;
            win_col     <= '0;
            win_dir     <= 2'd0;
          end
        end
        SCAN: begin
          if (idx_r != LAST_IDX) begin
            idx_r <= idx_r + IW'(1);
          end
          p1_win      <= p1_win | (|p1m_s);
          p2_win      <= p2_win | (|p2m_s);
          illegal     <= illegal | (cell_s == CELL_BAD);
          any_empty_r <= any_empty_r | (cell_s == CELL_EMPTY);
          // Only the first line found in scan order is reported.
          if (!found_r && (|hit_s)) begin
            found_r <= 1'b1;
            win_row <= row_s;
            win_col <= col_s;
            win_dir <= first_dir(hit_s);
          end
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          draw <= !any_empty_r && !p1_win && !p2_win;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_win_scanner.sv
// Self-checking bench for win_scanner: a 5x5/K=3 instance and a 4x4/K=4
// instance share one clock. Directed table vectors, randomized boards checked
// against a behavioural model, and hand sequences for the timing corners.
module tb_win_scanner;

  typedef struct packed {
    logic       p1;
    logic       p2;
    logic       drw;
    logic       ill;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] dir;
  } res_t;

  typedef struct {
    string        name;
    bit           sel;
    logic [127:0] b;
    res_t         e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start5, start4;
  logic [49:0] board5;
  logic [31:0] board4;
  logic        busy5, done5, p1_5, p2_5, draw5, ill5;
  logic [2:0]  row5, col5;
  logic [1:0]  dir5;
  logic        busy4, done4, p1_4, p2_4, draw4, ill4;
  logic [1:0]  row4, col4;
  logic [1:0]  dir4;

  int errors = 0;
  int total  = 0;

  win_scanner #(.N(5), .K(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .board(board5),
    .busy(busy5), .done(done5), .p1_win(p1_5), .p2_win(p2_5),
    .draw(draw5), .illegal(ill5), .win_row(row5), .win_col(col5),
    .win_dir(dir5)
  );

  win_scanner #(.N(4), .K(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .board(board4),
    .busy(busy4), .done(done4), .p1_win(p1_4), .p2_win(p2_4),
    .draw(draw4), .illegal(ill4), .win_row(row4), .win_col(col4),
    .win_dir(dir4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] b, input int idx,
                                       input logic [1:0] code);
    logic [127:0] t;
    t = b;
    t[2*idx +: 2] = code;
    return t;
  endfunction

  function automatic res_t mk(input bit p1, input bit p2, input bit drw,
                              input bit ill, input int row, input int col,
                              input int dir);
    res_t r;
    r.p1 = p1; r.p2 = p2; r.drw = drw; r.ill = ill;
    r.row = 3'(row); r.col = 3'(col); r.dir = 2'(dir);
    return r;
  endfunction

  // Reference: walk every start cell and direction vector, keep the first hit.
  function automatic res_t model(input logic [127:0] b, input int n, input int k);
    res_t e;
    bit found, empty, ok1, ok2;
    int dr, dc, er, ec;
    logic [1:0] v;
    e = '0; found = 0; empty = 0;
    for (int i = 0; i < n * n; i++) begin
      v = b[2*i +: 2];
      if (v == 2'b11) e.ill = 1'b1;
      if (v == 2'b00) empty = 1;
    end
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          dr = (d == 0) ? 0 : 1;
          dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
          er = r + dr * (k - 1);
          ec = c + dc * (k - 1);
          if (er < n && ec >= 0 && ec < n) begin
            ok1 = 1; ok2 = 1;
            for (int s = 0; s < k; s++) begin
              v = b[2*((r + dr*s) * n + c + dc*s) +: 2];
              if (v != 2'b01) ok1 = 0;
              if (v != 2'b10) ok2 = 0;
            end
            if (ok1) e.p1 = 1'b1;
            if (ok2) e.p2 = 1'b1;
            if ((ok1 || ok2) && !found) begin
              found = 1;
              e.row = 3'(r); e.col = 3'(c); e.dir = 2'(d);
            end
          end
        end
    e.drw = !empty && !e.p1 && !e.p2;
    return e;
  endfunction

  function automatic res_t get_res(input bit sel);
    res_t r;
    if (sel) begin
      r.p1 = p1_4; r.p2 = p2_4; r.drw = draw4; r.ill = ill4;
      r.row = {1'b0, row4}; r.col = {1'b0, col4}; r.dir = dir4;
    end else begin
      r.p1 = p1_5; r.p2 = p2_5; r.drw = draw5; r.ill = ill5;
      r.row = row5; r.col = col5; r.dir = dir5;
    end
    return r;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? done4 : done5;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy4 : busy5;
  endfunction

  // One scan: start, wait for done (bounded), check latency and results.
  // With disturb set, board is inverted and start re-asserted mid-scan.
  task automatic run_scan(input string tag, input bit sel, input logic [127:0] b,
                          input res_t e, input bit disturb);
    int cyc, n;
    bit seen;
    res_t got;
    n = sel ? 4 : 5;
    @(negedge clk);
    if (sel) begin board4 = b[31:0]; start4 = 1'b1; end
    else     begin board5 = b[49:0]; start5 = 1'b1; end
    @(posedge clk);
    #1;
    start4 = 1'b0; start5 = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, ".busy_on"}, int'(get_busy(sel)), 1);
      if (disturb && cyc == 5) begin
        if (sel) begin board4 = ~b[31:0]; start4 = 1'b1; end
        else     begin board5 = ~b[49:0]; start5 = 1'b1; end
      end
      if (disturb && cyc == 9) begin start4 = 1'b0; start5 = 1'b0; end
      if (get_done(sel)) seen = 1;
    end
    chk({tag, ".latency"}, cyc, n * n + 2);
    got = get_res(sel);
    chk({tag, ".busy_off"}, int'(get_busy(sel)), 0);
    chk({tag, ".p1_win"},  int'(got.p1),  int'(e.p1));
    chk({tag, ".p2_win"},  int'(got.p2),  int'(e.p2));
    chk({tag, ".draw"},    int'(got.drw), int'(e.drw));
    chk({tag, ".illegal"}, int'(got.ill), int'(e.ill));
    chk({tag, ".win_row"}, int'(got.row), int'(e.row));
    chk({tag, ".win_col"}, int'(got.col), int'(e.col));
    chk({tag, ".win_dir"}, int'(got.dir), int'(e.dir));
  endtask

  vec_t vecs[$];

  initial begin
    logic [127:0] b, full;
    vec_t v;
    int cyc, x;
    bit seen;
    res_t got;

    rst_n = 1'b0; start5 = 1'b0; start4 = 1'b0; board5 = '0; board4 = '0;

    // Directed vectors; expected values are worked out by hand.
    full = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        full = put(full, r*5 + c, (((c + 2*r) % 4) < 2) ? 2'b01 : 2'b10);

    v.sel = 0;
    v.name = "empty";  v.b = '0; v.e = mk(0,0,0,0,0,0,0); vecs.push_back(v);
    v.name = "row";    v.b = put(put(put('0,7,2'b01),8,2'b01),9,2'b01);
    v.e = mk(1,0,0,0,1,2,0); vecs.push_back(v);
    v.name = "adiag";  v.b = put(put(put('0,4,2'b10),8,2'b10),12,2'b10);
    v.e = mk(0,1,0,0,0,4,3); vecs.push_back(v);
    b = put(put(put('0,20,2'b01),21,2'b01),22,2'b01);
    v.name = "both";   v.b = put(put(put(b,0,2'b10),5,2'b10),10,2'b10);
    v.e = mk(1,1,0,0,0,0,1); vecs.push_back(v);
    v.name = "full";   v.b = full; v.e = mk(0,0,1,0,0,0,0); vecs.push_back(v);
    v.name = "full_bad"; v.b = put(full,12,2'b11); v.e = mk(0,0,1,1,0,0,0);
    vecs.push_back(v);
    v.name = "bad_cut"; v.b = put(put(put('0,7,2'b01),8,2'b01),9,2'b11);
    v.e = mk(0,0,0,1,0,0,0); vecs.push_back(v);
    v.name = "col_edge"; v.b = put(put(put('0,14,2'b10),19,2'b10),24,2'b10);
    v.e = mk(0,1,0,0,2,4,1); vecs.push_back(v);
    v.name = "wrap";   v.b = put(put(put('0,3,2'b01),4,2'b01),5,2'b01);
    v.e = mk(0,0,0,0,0,0,0); vecs.push_back(v);
    v.sel = 1;
    v.name = "n4_diag"; v.b = put(put(put(put('0,0,2'b01),5,2'b01),10,2'b01),15,2'b01);
    v.e = mk(1,0,0,0,0,0,2); vecs.push_back(v);
    v.name = "n4_short"; v.b = put(put(put('0,0,2'b01),1,2'b01),2,2'b01);
    v.e = mk(0,0,0,0,0,0,0); vecs.push_back(v);

    // Reset values.
    #22;
    chk("rst.busy", int'(busy5), 0);
    chk("rst.done", int'(done5), 0);
    got = get_res(0);
    chk("rst.res5", int'(got), 0);
    got = get_res(1);
    chk("rst.res4", int'(got), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_scan(vecs[i].name, vecs[i].sel, vecs[i].b, vecs[i].e, 1'b0);

    // Mid-scan board change plus start while busy: neither may matter.
    run_scan("isolate", 0, vecs[1].b, vecs[1].e, 1'b1);

    // Randomized boards against the reference model.
    for (int t = 0; t < 35; t++) begin
      int n;
      n = (t < 25) ? 5 : 4;
      b = '0;
      for (int i = 0; i < n * n; i++) begin
        x = $urandom_range(0, 15);
        b = put(b, i, (x < 5) ? 2'b00 : (x < 10) ? 2'b01 : (x < 15) ? 2'b10 : 2'b11);
      end
      run_scan($sformatf("rand%0d", t), (n == 4), b, model(b, n, (n == 4) ? 4 : 3), 1'b0);
    end

    // Back-to-back scans with start held, then result hold while idle.
    @(negedge clk);
    board5 = vecs[2].b[49:0];
    start5 = 1'b1;
    @(posedge clk);
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      cyc = 0; seen = 0;
      while (!seen && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (done5) seen = 1;
      end
      chk($sformatf("b2b.period%0d", pass), cyc, (pass == 0) ? 27 : 27);
    end
    start5 = 1'b0;
    repeat (30) @(negedge clk);
    chk("hold.busy", int'(busy5), 0);
    chk("hold.done", int'(done5), 0);
    chk("hold.p2_win", int'(p2_5), 1);
    chk("hold.win_col", int'(col5), 4);
    chk("hold.win_dir", int'(dir5), 3);

    // Reset mid-scan: sticky win visible, then cleared asynchronously.
    @(negedge clk);
    board5 = put(put(put('0,0,2'b01),1,2'b01),2,2'b01);
    start5 = 1'b1;
    @(posedge clk);
    #1;
    start5 = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst.busy_pre", int'(busy5), 1);
    chk("midrst.p1_pre", int'(p1_5), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", int'(busy5), 0);
    got = get_res(0);
    chk("midrst.res", int'(got), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst.no_done", int'(done5), 0);
    chk("midrst.idle", int'(busy5), 0);

    // Scanner still works after the abandoned scan.
    run_scan("after_rst", 0, vecs[3].b, vecs[3].e, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
